// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control FSM: decodes opcode and sequences IF/ID/EXE/MEM/WB, driving datapath enables/selects.
// Latency: outputs are combinational from (state, op, zero); 2-5 cycles per instruction depending on class.
// No backpressure: advances every CLK; optional INSTR_COUNT_EN adds a 32-bit retired-instruction counter.
module mc_control_fsm #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [OPW-1:0]    op,
  input  logic              zero,
  output logic              PCWre,
  output logic              IRWre,
  output logic              InsMemRW,
  output logic              mRD,
  output logic              mWR,
  output logic              RegWre,
  output logic              DBDataSrc,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic              ExtSel,
  output logic [1:0]        RegDst,
  output logic              WrRegDSrc,
  output logic [1:0]        PCSrc,
  output logic [ALUOPW-1:0] ALUOp,
  output logic [3:0]        state
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]       retired
`endif
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  localparam logic [OPW-1:0] OP_ADD   = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_AND   = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_OR    = OPW'(6'b010011);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(6'b011000);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(6'b100110);
  localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b010010);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b100111);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b110000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b110001);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b110100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b110101);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b111000);
  localparam logic [OPW-1:0] OP_JR    = OPW'(6'b111001);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b111010);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);

  state_t cur, nxt;

  logic is_rtype, is_itype, is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_jr, is_jal, is_jump, is_halt, is_andi_ori;

  // Opcode class decode; anything unlisted falls through as a NOP ALU op.
  always_comb begin
    is_rtype    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                  (op == OP_OR)  || (op == OP_SLL) || (op == OP_SLT);
    is_itype    = (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    is_lw       = (op == OP_LW);
    is_sw       = (op == OP_SW);
    is_beq      = (op == OP_BEQ);
    is_bne      = (op == OP_BNE);
    is_j        = (op == OP_J);
    is_jr       = (op == OP_JR);
    is_jal      = (op == OP_JAL);
    is_jump     = is_j || is_jr || is_jal;
    is_halt     = (op == OP_HALT);
    is_andi_ori = (op == OP_ANDI) || (op == OP_ORI);
  end

  // State register; reset forces fetch so an interrupted instruction restarts cleanly.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) cur <= S_IF;
    else        cur <= nxt;
  end

  assign state = cur;

  // Next-state sequencing per instruction class.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IF:     nxt = S_ID;
      S_ID: begin
        if (is_halt)               nxt = S_HALT;
        else if (is_jump)          nxt = S_IF;
        else if (is_beq || is_bne) nxt = S_EXE_BR;
        else if (is_lw || is_sw)   nxt = S_EXE_LS;
        else                       nxt = S_EXE_AL;
      end
      S_EXE_AL: nxt = S_WB_AL;
      S_WB_AL:  nxt = S_IF;
      S_EXE_BR: nxt = S_IF;
      S_EXE_LS: nxt = S_MEM;
      S_MEM:    nxt = is_lw ? S_WB_LD : S_IF;
      S_WB_LD:  nxt = S_IF;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IF;
    endcase
  end

  // Datapath controls; everything except InsMemRW is held low while Reset is asserted.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b1;
    mRD       = 1'b0;
    mWR       = 1'b0;
    RegWre    = 1'b0;
    DBDataSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    PCSrc     = 2'b00;
    ALUOp     = ALUOPW'(3'b000);
    if (Reset) begin
      IRWre   = (cur == S_IF);
      ALUSrcA = (op == OP_SLL);
      ALUSrcB = is_itype || is_lw || is_sw;
      ExtSel  = !is_andi_ori;
      case (op)
        OP_SUB, OP_BEQ, OP_BNE: ALUOp = ALUOPW'(3'b001);
        OP_SLL:                 ALUOp = ALUOPW'(3'b010);
        OP_OR, OP_ORI:          ALUOp = ALUOPW'(3'b011);
        OP_AND, OP_ANDI:        ALUOp = ALUOPW'(3'b100);
        OP_SLT, OP_SLTI:        ALUOp = ALUOPW'(3'b110);
        default:                ALUOp = ALUOPW'(3'b000);
      endcase
      // jal links PC+4 into $31; all other writes take DB into rd/rt.
      if (is_jal) begin
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
      end else begin
        RegDst    = is_rtype ? 2'b10 : 2'b01;
        WrRegDSrc = 1'b1;
      end
      if (is_j || is_jal) PCSrc = 2'b11;
      else if (is_jr)     PCSrc = 2'b10;
      case (cur)
        S_ID: begin
          PCWre  = is_jump;
          RegWre = is_jal;
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = ((is_beq && zero) || (is_bne && !zero)) ? 2'b01 : 2'b00;
        end
        S_MEM: begin
          mRD       = is_lw;
          mWR       = is_sw;
          DBDataSrc = is_lw;
          PCWre     = is_sw;
        end
        S_WB_LD: begin
          PCWre     = 1'b1;
          RegWre    = 1'b1;
          DBDataSrc = is_lw;
        end
        S_WB_AL: begin
          PCWre  = 1'b1;
          RegWre = is_rtype || is_itype;
        end
        default: ;
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] irq_cnt;

  // Count one per instruction: the cycle that returns to fetch from any other state.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)                          irq_cnt <= 32'd0;
    else if (nxt == S_IF && cur != S_IF) irq_cnt <= irq_cnt + 32'd1;
  end

  assign retired = irq_cnt;
`endif

endmodule
